// File: rtl/tile_pkg.sv
// tile_pkg: shared word-type encodings and dispatcher state encoding.
package tile_pkg;
  localparam logic [2:0] WT_ADDR  = 3'd0;
  localparam logic [2:0] WT_ZOOM  = 3'd1;
  localparam logic [2:0] WT_CREAL = 3'd2;
  localparam logic [2:0] WT_CIMAG = 3'd3;
  localparam logic [2:0] WT_END   = 3'd4;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_FORWARD,
    ST_DRAIN
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request strictly after last_grant.
module rr_arbiter #(
  parameter int N = 4,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic [GW-1:0] grant,
  output logic          grant_valid
);
  logic [GW-1:0] idx;
  always_comb begin
    grant = '0;
    grant_valid = 1'b0;
    idx = '0;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int k = N; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % N);
      if (req[idx]) begin
        grant = idx;
        grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tile_job_dispatcher.sv
// tile_job_dispatcher: routes job packets to idle tile solvers round-robin.
// Define TILE_DISPATCH_PROTOCOL_CHECK_EN to reject packets whose first word is not an address.
module tile_job_dispatcher
  import tile_pkg::*;
#(
  parameter int NUM_SOLVERS = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_end_of_stream,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [NUM_SOLVERS-1:0]         solver_idle,
  output logic [NUM_SOLVERS-1:0]         out_valid,
  input  logic [NUM_SOLVERS-1:0]         out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_end_of_stream,
  output logic                           busy,
  output logic [$clog2(NUM_SOLVERS)-1:0] active_solver,
  output logic                           proto_error
);
  localparam int GW = $clog2(NUM_SOLVERS);
  state_t state_q, state_d;
  logic [NUM_SOLVERS-1:0] pending_q, pending_d;
  logic [GW-1:0] last_grant_q, last_grant_d, active_q, active_d, grant;
  logic grant_valid;

  rr_arbiter #(.N(NUM_SOLVERS), .GW(GW)) u_arb (
    .req(solver_idle & ~pending_q),
    .last_grant(last_grant_q),
    .grant(grant),
    .grant_valid(grant_valid)
  );

  always_comb begin
    state_d = state_q;
    pending_d = pending_q & solver_idle;
    last_grant_d = last_grant_q;
    active_d = active_q;
    in_ready = 1'b0;
    out_valid = '0;
    proto_error = 1'b0;
    out_data = in_data;
    out_end_of_stream = in_end_of_stream;
    case (state_q)
      ST_IDLE: state_d = in_valid ? ST_SELECT : ST_IDLE;
      ST_SELECT: begin
`ifdef TILE_DISPATCH_PROTOCOL_CHECK_EN
        if (in_valid && in_data[DATA_WIDTH-1 -: 3] != WT_ADDR) begin
          proto_error = 1'b1;
          state_d = ST_DRAIN;
        end else if (in_valid && grant_valid) begin
          active_d = grant;
          state_d = ST_FORWARD;
        end
`else
        if (grant_valid) begin
          active_d = grant;
          state_d = ST_FORWARD;
        end
`endif
      end
      ST_FORWARD: begin
        out_valid[active_q] = in_valid;
        in_ready = out_ready[active_q];
        // Setting pending after the clear above gives set priority.
        if (in_valid && in_ready && in_end_of_stream) begin
          pending_d[active_q] = 1'b1;
          last_grant_d = active_q;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        in_ready = 1'b1;
        state_d = (in_valid && in_end_of_stream) ? ST_IDLE : ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) begin
      in_ready = 1'b0;
      out_valid = '0;
      proto_error = 1'b0;
    end
  end

  assign busy = !reset && state_q != ST_IDLE;
  assign active_solver = reset ? '0 : active_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pending_q <= '0;
      last_grant_q <= GW'(NUM_SOLVERS - 1);
      active_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      last_grant_q <= last_grant_d;
      active_q <= active_d;
    end
  end
endmodule

// File: tb/tb_tile_job_dispatcher.sv
// tb_tile_job_dispatcher: directed self-checking bench for tile_job_dispatcher.
module tb_tile_job_dispatcher;
  logic clock = 1'b0;
  logic reset;
  logic in_valid, in_ready, in_eos;
  logic [31:0] in_data, out_data;
  logic [3:0] solver_idle, out_valid, out_ready;
  logic out_eos, busy, proto_error;
  logic [1:0] active_solver;
  logic [31:0] pkt[5];
  int checks = 0;
  int errors = 0;

  tile_job_dispatcher #(.NUM_SOLVERS(4), .DATA_WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_end_of_stream(in_eos),
    .in_data(in_data),
    .solver_idle(solver_idle),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_end_of_stream(out_eos),
    .busy(busy),
    .active_solver(active_solver),
    .proto_error(proto_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_eos = 1'b0;
    in_data = '0;
    out_ready = 4'hF;
    solver_idle = 4'hF;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_active"}, active_solver, 0);
    chk({tag, "_proto"}, proto_error, 0);
  endtask

  // Send words first..last-1 of pkt to solver g; word 4 carries end_of_stream.
  task automatic send(input int g, input int first, input int last);
    int w;
    for (int i = first; i < last; i++) begin
      in_valid = 1'b1;
      in_data = pkt[i];
      in_eos = (i == 4);
      #1;
      w = 0;
      while (!in_ready && w < 20) begin
        tick();
        w++;
      end
      chk("xfer_ready", in_ready, 1);
      chk("xfer_valid", out_valid, 64'(1 << g));
      chk("xfer_data", out_data, pkt[i]);
      chk("xfer_eos", out_eos, (i == 4));
      chk("xfer_grant", active_solver, g);
      tick();
    end
    in_valid = 1'b0;
    in_eos = 1'b0;
  endtask

  initial begin
    pkt[0] = 32'h0000_0001;
    pkt[1] = 32'h2000_0002;
    pkt[2] = 32'h4000_0003;
    pkt[3] = 32'h6000_0006;
    pkt[4] = 32'h8000_0000;
    reset = 1'b1;
    in_valid = 1'b1;
    in_eos = 1'b0;
    in_data = pkt[0];
    out_ready = 4'hF;
    solver_idle = 4'hF;
    tick();
    tick();
    #1;
    chk_quiet("in_reset");
    do_reset();
    #1;
    chk_quiet("after_reset");

    // Single packet to solver 0; busy falls once eos transfers.
    send(0, 0, 5);
    chk("t1_busy_after", busy, 0);
    chk("t1_out_valid_idle", out_valid, 0);
    // pending[0] blocks solver 0 until it reports not idle.
    solver_idle = 4'b0001;
    in_valid = 1'b1;
    in_data = pkt[0];
    for (int i = 0; i < 5; i++) tick();
    chk("t1_pending_stall_ready", in_ready, 0);
    chk("t1_pending_stall_busy", busy, 1);
    solver_idle = 4'b0000;
    tick();
    solver_idle = 4'b0001;
    send(0, 0, 5);

    // Back-to-back packets rotate 0..3, then the fifth stalls.
    do_reset();
    send(0, 0, 5);
    send(1, 0, 5);
    send(2, 0, 5);
    send(3, 0, 5);
    in_valid = 1'b1;
    in_data = pkt[0];
    for (int i = 0; i < 6; i++) tick();
    chk("t2_stall_ready", in_ready, 0);
    chk("t2_stall_valid", out_valid, 0);
    chk("t2_stall_busy", busy, 1);
    solver_idle = 4'b1101;
    tick();
    solver_idle = 4'hF;
    send(1, 0, 5);

    // Gaps and backpressure mid-packet; grant holds despite solver_idle drop.
    do_reset();
    send(0, 0, 1);
    solver_idle = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_gap_valid", out_valid, 0);
      chk("t3_gap_busy", busy, 1);
      chk("t3_gap_grant", active_solver, 0);
      tick();
    end
    in_valid = 1'b1;
    in_data = pkt[1];
    out_ready = 4'b1110;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_bp_ready", in_ready, 0);
      chk("t3_bp_valid", out_valid, 4'b0001);
      chk("t3_bp_data", out_data, pkt[1]);
      tick();
    end
    out_ready = 4'hF;
    send(0, 1, 5);
    solver_idle = 4'hF;
    send(1, 0, 5);

    // No idle solver: wait indefinitely, then solver 3 gets it.
    do_reset();
    solver_idle = 4'b0000;
    in_valid = 1'b1;
    in_data = pkt[0];
    for (int i = 0; i < 8; i++) tick();
    chk("t4_none_ready", in_ready, 0);
    chk("t4_none_valid", out_valid, 0);
    solver_idle = 4'b1000;
    tick();
    chk("t4_grant3", active_solver, 3);
    chk("t4_valid3", out_valid, 4'b1000);
    send(3, 0, 5);

    // Reset after two words abandons the packet.
    do_reset();
    send(0, 0, 2);
    in_valid = 1'b1;
    in_data = pkt[2];
    reset = 1'b1;
    #1;
    chk_quiet("t5_in_reset");
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_quiet("t5_after_reset");
    send(0, 0, 5);

    // Malformed first word (type 2).
    do_reset();
    in_valid = 1'b1;
    in_data = 32'h4000_0003;
    tick();
    #1;
`ifdef TILE_DISPATCH_PROTOCOL_CHECK_EN
    chk("t6_proto_pulse", proto_error, 1);
    chk("t6_sel_ready", in_ready, 0);
    chk("t6_sel_valid", out_valid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      in_data = pkt[i];
      in_eos = (i == 4);
      #1;
      chk("t6_drain_proto", proto_error, 0);
      chk("t6_drain_ready", in_ready, 1);
      chk("t6_drain_valid", out_valid, 0);
      tick();
    end
    in_valid = 1'b0;
    in_eos = 1'b0;
    #1;
    chk("t6_busy_after", busy, 0);
    send(0, 0, 5);
`else
    chk("t6_noproto_sel", proto_error, 0);
    tick();
    chk("t6_noproto_valid", out_valid, 4'b0001);
    chk("t6_noproto_data", out_data, 32'h4000_0003);
    chk("t6_noproto_fwd", proto_error, 0);
    send(0, 0, 5);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
